// File: rtl/bp_fe_bht_pkg.sv
// Shared types and saturating-counter helpers for the bimodal BHT controller.
package bp_fe_bht_pkg;

  localparam int unsigned bht_idx_max_lp = 16;
  localparam int unsigned bht_cnt_max_lp = 8;

  typedef logic [bht_idx_max_lp-1:0] bht_idx_t;
  typedef logic [bht_cnt_max_lp-1:0] bht_cnt_t;

  typedef enum logic [0:0] {INIT, RUN} bht_ctrl_state_e;

  // Fields are sized for the widest supported configuration; users slice to width.
  typedef struct packed {
    bht_idx_t idx;
    bht_cnt_t cnt;
  } bht_upd_s;

  function automatic bht_cnt_t bht_wnt(input int unsigned n);
    return bht_cnt_t'((32'd1 << (n - 32'd1)) - 32'd1);
  endfunction

  function automatic bht_cnt_t sat_inc(input bht_cnt_t c, input int unsigned n);
    return (c >= bht_cnt_t'((32'd1 << n) - 32'd1)) ? c : c + bht_cnt_t'(1);
  endfunction

  function automatic bht_cnt_t sat_dec(input bht_cnt_t c);
    return (c == '0) ? c : c - bht_cnt_t'(1);
  endfunction

endpackage

// File: rtl/bp_fe_bht_upd_fifo.sv
// Circular update queue; entries are presented oldest-first for forwarding.
module bp_fe_bht_upd_fifo
  import bp_fe_bht_pkg::*;
#(
  parameter int unsigned els_p = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             enq_i,
  input  bht_upd_s         data_i,
  input  logic             deq_i,
  output logic             full_o,
  output logic             empty_o,
  output bht_upd_s         entries_o [els_p],
  output logic [els_p-1:0] valid_o
);

  localparam int unsigned ptr_w_lp = $clog2(els_p);
  typedef logic [ptr_w_lp-1:0] ptr_t;
  typedef logic [ptr_w_lp:0]   cnt_t;

  ptr_t     r_rptr, r_wptr;
  cnt_t     r_cnt;
  bht_upd_s r_mem [els_p];
  logic     w_enq, w_deq;

  assign full_o  = (r_cnt == cnt_t'(els_p));
  assign empty_o = (r_cnt == '0);
  assign w_enq   = enq_i & ~full_o;
  assign w_deq   = deq_i & ~empty_o;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else if (clear_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + ptr_t'(1);
      if (w_deq) r_rptr <= r_rptr + ptr_t'(1);
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + cnt_t'(1);
        2'b01:   r_cnt <= r_cnt - cnt_t'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr] <= data_i;
  end

  always_comb begin
    for (int i = 0; i < els_p; i++) begin
      entries_o[i] = r_mem[ptr_t'(r_rptr + ptr_t'(i))];
      valid_o[i]   = (cnt_t'(i) < r_cnt);
    end
  end

endmodule

// File: rtl/bp_fe_bht_ctrl.sv
// 1RW bimodal BHT sequencer: init sweep, read-priority arbitration, queued updates.
// Define BP_FE_BHT_CTRL_FWD_EN to forward queued updates into prediction responses.
module bp_fe_bht_ctrl
  import bp_fe_bht_pkg::*;
#(
  parameter int unsigned bht_idx_width_p   = 9,
  parameter int unsigned bp_cnt_sat_bits_p = 2,
  parameter int unsigned upd_fifo_els_p    = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic                         r_v_i,
  output logic                         r_ready_o,
  input  logic [bht_idx_width_p-1:0]   idx_r_i,
  output logic                         predict_v_o,
  output logic                         predict_o,
  output logic [bp_cnt_sat_bits_p-1:0] predict_cnt_o,
  input  logic                         w_v_i,
  output logic                         w_ready_o,
  input  logic [bht_idx_width_p-1:0]   idx_w_i,
  input  logic [bp_cnt_sat_bits_p-1:0] cnt_w_i,
  input  logic                         taken_i,
  output logic                         mem_v_o,
  output logic                         mem_w_o,
  output logic [bht_idx_width_p-1:0]   mem_addr_o,
  output logic [bp_cnt_sat_bits_p-1:0] mem_data_o,
  input  logic [bp_cnt_sat_bits_p-1:0] mem_data_i,
  output logic                         init_done_o
);

  localparam int unsigned W = bht_idx_width_p;
  localparam int unsigned N = bp_cnt_sat_bits_p;
  localparam bht_cnt_t    wnt_full_lp = bht_wnt(N);
  localparam logic [N-1:0] wnt_lp = wnt_full_lp[N-1:0];

  bht_ctrl_state_e r_state;
  logic [W-1:0]    r_init_idx;
  logic            r_init_done, r_pred_v;
  logic            w_full, w_empty, w_enq, w_deq, w_unused;
  bht_cnt_t        w_upd_cnt;
  bht_upd_s        w_enq_data, w_head;
  bht_upd_s        w_entries [upd_fifo_els_p];
  logic [upd_fifo_els_p-1:0] w_valid;
  logic [N-1:0]    w_pred_cnt;

  assign w_upd_cnt  = taken_i ? sat_inc(bht_cnt_t'(cnt_w_i), N) : sat_dec(bht_cnt_t'(cnt_w_i));
  assign w_enq_data = '{idx: bht_idx_t'(idx_w_i), cnt: w_upd_cnt};
  assign w_head     = w_entries[0];
  assign w_ready_o  = (r_state == RUN) & ~w_full;
  assign w_enq      = w_v_i & w_ready_o;

  bp_fe_bht_upd_fifo #(
    .els_p(upd_fifo_els_p)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .clear_i  (flush_i),
    .enq_i    (w_enq),
    .data_i   (w_enq_data),
    .deq_i    (w_deq),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .entries_o(w_entries),
    .valid_o  (w_valid)
  );

  // A full queue steals the port from reads so updates can never be starved.
  always_comb begin
    mem_v_o    = 1'b0;
    mem_w_o    = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    r_ready_o  = 1'b0;
    w_deq      = 1'b0;
    if (r_state == INIT) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = r_init_idx;
      mem_data_o = wnt_lp;
    end else if (w_full || (!r_v_i && !w_empty)) begin
      mem_v_o    = 1'b1;
      mem_w_o    = 1'b1;
      mem_addr_o = w_head.idx[W-1:0];
      mem_data_o = w_head.cnt[N-1:0];
      w_deq      = 1'b1;
    end else if (r_v_i) begin
      mem_v_o    = 1'b1;
      mem_addr_o = idx_r_i;
      r_ready_o  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= INIT;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_pred_v    <= 1'b0;
    end else if (flush_i) begin
      r_state     <= INIT;
      r_init_idx  <= '0;
      r_init_done <= 1'b0;
      r_pred_v    <= 1'b0;
    end else begin
      r_pred_v <= r_ready_o;
      if (r_state == INIT) begin
        r_init_idx <= r_init_idx + W'(1);
        if (&r_init_idx) begin
          r_state     <= RUN;
          r_init_done <= 1'b1;
        end
      end
    end
  end

`ifdef BP_FE_BHT_CTRL_FWD_EN
  logic         r_fwd_hit, w_fwd_hit;
  logic [N-1:0] r_fwd_cnt, w_fwd_cnt;

  // Later (younger) matches override earlier ones.
  always_comb begin
    w_fwd_hit = 1'b0;
    w_fwd_cnt = '0;
    for (int i = 0; i < upd_fifo_els_p; i++) begin
      if (w_valid[i] && (w_entries[i].idx == bht_idx_t'(idx_r_i))) begin
        w_fwd_hit = 1'b1;
        w_fwd_cnt = w_entries[i].cnt[N-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_fwd_hit <= 1'b0;
      r_fwd_cnt <= '0;
    end else begin
      r_fwd_hit <= w_fwd_hit & r_ready_o;
      r_fwd_cnt <= w_fwd_cnt;
    end
  end

  assign w_pred_cnt = r_fwd_hit ? r_fwd_cnt : mem_data_i;
`else
  assign w_pred_cnt = mem_data_i;
`endif

  always_comb begin
    w_unused = ^w_valid;
    for (int i = 0; i < upd_fifo_els_p; i++) w_unused = w_unused ^ (^w_entries[i]);
  end

  assign init_done_o   = r_init_done;
  assign predict_v_o   = r_pred_v;
  assign predict_cnt_o = r_pred_v ? w_pred_cnt : '0;
  assign predict_o     = r_pred_v & (w_pred_cnt > wnt_lp);

endmodule

// File: tb/tb_bp_fe_bht_ctrl.sv
// Scoreboard bench for bp_fe_bht_ctrl with an SRAM model and a queue-level reference.
module tb_bp_fe_bht_ctrl;

  localparam int IW = 9, N = 2, D = 4, ELS = 512, WNT = 1, CMAX = 3;

  logic clk_i = 1'b0, reset_i = 1'b1, flush_i = 1'b0;
  logic r_v_i = 1'b0, w_v_i = 1'b0, taken_i = 1'b0;
  logic [IW-1:0] idx_r_i = '0, idx_w_i = '0;
  logic [N-1:0]  cnt_w_i = '0, mem_data_i = '0;
  logic r_ready_o, predict_v_o, predict_o, w_ready_o, mem_v_o, mem_w_o, init_done_o;
  logic [N-1:0]  predict_cnt_o, mem_data_o;
  logic [IW-1:0] mem_addr_o;

  always #5 clk_i = ~clk_i;

  bp_fe_bht_ctrl #(
    .bht_idx_width_p(IW), .bp_cnt_sat_bits_p(N), .upd_fifo_els_p(D)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(flush_i),
    .r_v_i(r_v_i), .r_ready_o(r_ready_o), .idx_r_i(idx_r_i),
    .predict_v_o(predict_v_o), .predict_o(predict_o), .predict_cnt_o(predict_cnt_o),
    .w_v_i(w_v_i), .w_ready_o(w_ready_o), .idx_w_i(idx_w_i), .cnt_w_i(cnt_w_i),
    .taken_i(taken_i), .mem_v_o(mem_v_o), .mem_w_o(mem_w_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .init_done_o(init_done_o)
  );

  // SRAM macro model; read data is garbage unless a read was strobed.
  logic [N-1:0] sram [ELS];
  always @(posedge clk_i) begin
    if (mem_v_o && mem_w_o) sram[mem_addr_o] <= mem_data_o;
    if (mem_v_o && !mem_w_o) mem_data_i <= sram[mem_addr_o];
    else mem_data_i <= N'($urandom);
  end

  typedef struct { int idx; int cnt; } upd_t;
  upd_t upd_q[$];
  int   pred_q[$];
  int   tbl [ELS];
  int   init_pos = 0;
  int   vectors = 0, errors = 0;

  function automatic int sat(input int c, input bit t);
    if (t) return (c < CMAX) ? c + 1 : CMAX;
    return (c > 0) ? c - 1 : 0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: evaluates each cycle mid-period, then advances the model for the coming edge.
  initial begin
    bit seen_reset, running, exp_wr, exp_rd;
    int sz, ei, ec;
    seen_reset = 0;
    forever begin
      @(negedge clk_i);
      if (reset_i) begin
        if (!seen_reset) begin
          seen_reset = 1;
          chk("reset_init_done", int'(init_done_o), 0);
          chk("reset_pred_v", int'(predict_v_o), 0);
          chk("reset_r_ready", int'(r_ready_o), 0);
          chk("reset_w_ready", int'(w_ready_o), 0);
          chk("reset_mem_v", int'(mem_v_o), 1);
          chk("reset_mem_addr", int'(mem_addr_o), 0);
        end
        init_pos = 0;
        upd_q.delete();
        pred_q.delete();
      end else begin
        running = (init_pos == ELS);
        sz      = upd_q.size();
        exp_wr  = !running || sz == D || (!r_v_i && sz > 0);
        exp_rd  = running && r_v_i && sz < D;
        chk("init_done", int'(init_done_o), int'(running));
        chk("w_ready", int'(w_ready_o), int'(running && sz < D));
        chk("r_ready", int'(r_ready_o), int'(exp_rd));
        chk("mem_v", int'(mem_v_o), int'(exp_wr || exp_rd));
        if (exp_wr) begin
          chk("mem_w", int'(mem_w_o), 1);
          if (!running) begin
            ei = init_pos;
            ec = WNT;
            init_pos++;
          end else begin
            ei = upd_q[0].idx;
            ec = upd_q[0].cnt;
            upd_q.delete(0);
          end
          chk("wr_addr", int'(mem_addr_o), ei);
          chk("wr_data", int'(mem_data_o), ec);
          tbl[ei] = ec;
        end else if (exp_rd) begin
          chk("mem_w", int'(mem_w_o), 0);
          chk("rd_addr", int'(mem_addr_o), int'(idx_r_i));
        end
        if (pred_q.size() > 0) begin
          ec = pred_q.pop_front();
          chk("pred_v", int'(predict_v_o), 1);
          chk("pred_cnt", int'(predict_cnt_o), ec);
          chk("pred_taken", int'(predict_o), int'(ec > WNT));
        end else begin
          chk("pred_v_idle", int'(predict_v_o), 0);
        end
        if (flush_i) begin
          upd_q.delete();
          init_pos = 0;
        end else begin
          if (exp_rd) begin
            ec = tbl[idx_r_i];
`ifdef BP_FE_BHT_CTRL_FWD_EN
            foreach (upd_q[k]) if (upd_q[k].idx == int'(idx_r_i)) ec = upd_q[k].cnt;
`endif
            pred_q.push_back(ec);
          end
          if (w_v_i && running && sz < D)
            upd_q.push_back('{idx: int'(idx_w_i), cnt: sat(int'(cnt_w_i), taken_i)});
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk_i);
      #2;
    end
  endtask

  task automatic wait_init();
    int k;
    k = 0;
    while (!init_done_o && k < 700) begin
      cyc();
      k++;
    end
    chk("init_timeout", int'(init_done_o), 1);
  endtask

  task automatic upd(input int idx, input int cnt, input bit t);
    w_v_i   = 1'b1;
    idx_w_i = IW'(idx);
    cnt_w_i = N'(cnt);
    taken_i = t;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    cyc(3);
    reset_i = 1'b0;
    wait_init();
    // First read after init sees the swept weak-not-taken value.
    r_v_i = 1'b1; idx_r_i = IW'(5); cyc(); r_v_i = 1'b0; cyc(2);
    upd(7, 3, 1'b1); cyc(); upd(7, 0, 1'b0); cyc(); upd(7, 1, 1'b1); cyc();
    w_v_i = 1'b0; cyc(3);
    r_v_i = 1'b1; idx_r_i = IW'(7); cyc(); r_v_i = 1'b0; cyc(2);
    // Back-pressure: reads held while the queue fills.
    r_v_i = 1'b1; idx_r_i = IW'(20);
    for (int i = 0; i < 6; i++) begin
      upd(30 + i, i % 4, (i % 2) == 1);
      cyc();
    end
    w_v_i = 1'b0; cyc(3); r_v_i = 1'b0; cyc(6);
    // Flush with two queued updates and a read in the flush cycle.
    r_v_i = 1'b1; idx_r_i = IW'(40);
    upd(40, 1, 1'b1); cyc(); upd(41, 2, 1'b0); cyc();
    w_v_i = 1'b0; flush_i = 1'b1; cyc(); flush_i = 1'b0; r_v_i = 1'b0;
    wait_init();
    upd(9, 1, 1'b1); cyc(); w_v_i = 1'b0;
    r_v_i = 1'b1; idx_r_i = IW'(9); cyc(); r_v_i = 1'b0; cyc(3);
    for (int c = 0; c < 3000; c++) begin
      r_v_i   = ($urandom_range(0, 1) != 0);
      idx_r_i = IW'($urandom_range(0, 15));
      w_v_i   = ($urandom_range(0, 2) != 0);
      idx_w_i = IW'($urandom_range(0, 15));
      cnt_w_i = N'($urandom_range(0, 3));
      taken_i = ($urandom_range(0, 1) != 0);
      flush_i = ($urandom_range(0, 499) == 0);
      cyc();
    end
    r_v_i = 1'b0; w_v_i = 1'b0; flush_i = 1'b0;
    wait_init();
    cyc(10);
    chk("drain", upd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/bp_fe_bht_ctrl.md
Name: bp_fe_bht_ctrl

Overview:
Controller that sequences a single-port (1RW) bimodal branch-history-table SRAM for the front end.
- Clears the table after reset or flush, serves prediction reads with priority, and buffers resolved-branch updates in a small queue that drains into idle memory cycles.
- Sits between the fetch/predict pipeline, the backend update path, and the BHT memory macro.

Parameters:
bht_idx_width_p, 9, BHT index width; els = 2**bht_idx_width_p entries
bp_cnt_sat_bits_p, 2, saturating-counter width N
upd_fifo_els_p, 4, update-queue depth (power of 2, >=2)

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-high
flush_i  in  1  re-initialise table, drop queued updates
r_v_i  in  1  prediction read request
r_ready_o  out  1  read accepted this cycle
idx_r_i  in  bht_idx_width_p  read index
predict_v_o  out  1  prediction valid (1 cycle after accepted read)
predict_o  out  1  taken prediction
predict_cnt_o  out  N  counter value read (carried to backend as metadata)
w_v_i  in  1  update request
w_ready_o  out  1  update queue can accept
idx_w_i  in  bht_idx_width_p  update index
cnt_w_i  in  N  counter snapshot from prediction time
taken_i  in  1  resolved direction
mem_v_o  out  1  memory access strobe
mem_w_o  out  1  1=write, 0=read
mem_addr_o  out  bht_idx_width_p  memory index
mem_data_o  out  N  write data
mem_data_i  in  N  read data, valid 1 cycle after a read strobe
init_done_o  out  1  table initialised

Behaviour:
- Reset (async): state INIT, init_idx=0, queue empty. All outputs 0 except those driven by the INIT sweep in the first cycle.
- Weak-not-taken value WNT = 2**(N-1)-1. The prediction is taken iff the counter is greater than WNT.
- INIT state:
  - Each cycle: mem_v_o=1, mem_w_o=1, mem_addr_o=init_idx, mem_data_o=WNT; init_idx increments.
  - After writing entry els-1, go to RUN; init_done_o=1 from the next cycle.
  - r_ready_o=0 and w_ready_o=0 throughout INIT.
- RUN state, per-cycle priority:
  1. Queue full: dequeue and write the head entry; r_ready_o=0.
  2. r_v_i: issue the read; r_ready_o=1.
  3. Queue non-empty: dequeue and write the head entry.
  4. Otherwise: memory idle.
- Read latency is exactly 1 cycle:
  - predict_v_o=1, predict_cnt_o=mem_data_i, predict_o=(mem_data_i>WNT).
  - predict_v_o is 0 whenever no read was issued in the previous cycle.
- Update enqueue on w_v_i & w_ready_o:
  - Stored value = taken_i ? sat_inc(cnt_w_i) : sat_dec(cnt_w_i).
  - Increment saturates at 2**N-1; decrement saturates at 0.
- w_ready_o = RUN & ~full. It is computed from the current occupancy only: no credit for a same-cycle dequeue.
- Simultaneous enqueue and dequeue leave occupancy unchanged. Pointers wrap modulo upd_fifo_els_p.
- Writes to the same index apply in queue order; last write wins.
- flush_i, any state, synchronous:
  - Next cycle: state INIT, init_idx=0, queue emptied, init_done_o=0, predict_v_o=0 (a read issued in the flush cycle is dropped).
  - flush_i during INIT restarts the sweep at 0.
- Reset mid-sweep or mid-drain: immediately returns to the reset state.

Optional Feature:
BP_FE_BHT_CTRL_FWD_EN
- Defined:
  - An accepted read's index is compared with all valid queue entries.
  - On a match, the youngest matching entry's stored value replaces mem_data_i for predict_o and predict_cnt_o in the response cycle.
  - The comparison is captured at issue; entries dequeued in between still forward.
- Undefined: no comparison; predictions may use stale counters while updates are queued.

Decomposition:
- Shared package bp_fe_bht_pkg holds:
  - bht_ctrl_state_e {INIT, RUN}
  - the bht_upd_s struct {idx, cnt}
  - functions sat_inc, sat_dec and the WNT constant, all parameterised by N
- One natural sub-module, bp_fe_bht_upd_fifo: circular queue holding bht_upd_s, exposing full/empty and, for forwarding, all entries plus valid bits.

Test Plan (defaults: idx width 9, N=2, WNT=1, depth 4):
- Reset, then idle: 512 consecutive write strobes with data 1 at addresses 0..511; init_done_o rises on cycle 513; no r_ready_o before that.
- After init, read idx 5: predict_v_o one cycle later, predict_cnt_o=1, predict_o=0.
- Saturation:
  - Update idx 7, cnt 3, taken=1 writes 3.
  - Update idx 7, cnt 0, taken=0 writes 0.
  - Update cnt 1, taken=1 writes 2; a later read of idx 7 returns predict_o=1.
- Back-pressure:
  - Hold r_v_i=1 while enqueuing 4 updates: w_ready_o drops at full.
  - Next cycle: r_ready_o=0 and the head update is written.
  - No updates lost; write order matches enqueue order.
- flush_i mid-RUN with 2 queued updates and a read in flight: predict_v_o=0 next cycle, queue discarded, full 512-cycle sweep repeats.
- With BP_FE_BHT_CTRL_FWD_EN: enqueue update idx 9, taken=1, cnt 1, then immediately read idx 9 while the update is still queued: predict_cnt_o=2, predict_o=1. Without the macro: predict_cnt_o=1.
